// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, state enums and bit-timing helper for the pin-scan UART receiver
package uart_pkg;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} byte_state_t;
  typedef enum logic [1:0] {COLLECT, CR, LF, HUNT} line_state_t;
  // Clocks per bit (half = 0) or per half bit (half = 1), integer division.
  function automatic int bit_time(input int clk_hz, input int baud, input bit half);
    return half ? (clk_hz / baud) / 2 : clk_hz / baud;
  endfunction
endpackage

// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 byte receiver with 2-flop input synchronizer
//   clk, rst_n (async, active low), rx (serial in, idles high)
//   byte_o (last good byte), byte_valid (pulse per good byte), frame_err (pulse on low stop bit)
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] byte_o,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int DIV  = bit_time(CLOCK_FREQ, BAUD_RATE, 1'b0);
  localparam int HALF = bit_time(CLOCK_FREQ, BAUD_RATE, 1'b1);
  if (DIV >= (1 << 20) || DIV < 4) begin : g_bad_div
    $fatal(1, "uart_rx_byte: clocks per bit out of range");
  end
  byte_state_t st;
  logic        rx_m, rx_s, rx_d;
  logic [19:0] cnt;
  logic [2:0]  pos;
  logic [7:0]  sh;
  logic        tick;
  // The counter is loaded with the interval and the sample happens on the
  // cycle it would reach zero, so samples land exactly HALF / DIV after the load.
  assign tick = cnt == 20'd1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_m       <= 1'b1;
      rx_s       <= 1'b1;
      rx_d       <= 1'b1;
      st         <= IDLE;
      cnt        <= '0;
      pos        <= '0;
      sh         <= '0;
      byte_o     <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_m       <= rx;
      rx_s       <= rx_m;
      rx_d       <= rx_s;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (cnt != '0) cnt <= cnt - 20'd1;
      case (st)
        IDLE: if (rx_d && !rx_s) begin
          cnt <= 20'(HALF);
          st  <= START;
        end
        START: if (tick) begin
          if (rx_s) st <= IDLE;
          else begin
            cnt <= 20'(DIV);
            pos <= '0;
            st  <= DATA;
          end
        end
        DATA: if (tick) begin
          sh[pos] <= rx_s;
          cnt     <= 20'(DIV);
          pos     <= pos + 3'd1;
          if (pos == 3'd7) st <= STOP;
        end
        STOP: if (tick) begin
          if (rx_s) begin
            byte_o     <= sh;
            byte_valid <= 1'b1;
          end else frame_err <= 1'b1;
          st <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: rtl/uart_line_rx.sv
// uart_line_rx: assembles "b0 b1 b2 b3 CR LF" lines into 32-bit words on a valid/ready port
//   clk, rst_n (async, active low), rx (serial in)
//   byte_o/byte_valid/frame_err from the byte receiver
//   word_o/word_valid/word_ready holding register, line_err and overrun one-cycle pulses
module uart_line_rx
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ = 50000000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic [7:0]  byte_o,
  output logic        byte_valid,
  output logic [31:0] word_o,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        frame_err,
  output logic        line_err,
  output logic        overrun
);
  line_state_t st;
  logic [1:0]  idx;
  logic [31:0] acc;
  logic        done;
  uart_rx_byte #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) u_byte (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .byte_o(byte_o),
    .byte_valid(byte_valid),
    .frame_err(frame_err)
  );
  assign done = byte_valid && st == LF && byte_o == CHR_LF;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= COLLECT;
      idx        <= '0;
      acc        <= '0;
      word_o     <= '0;
      word_valid <= 1'b0;
      line_err   <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      line_err <= 1'b0;
      overrun  <= 1'b0;
      if (done) begin
        if (!word_valid || word_ready) begin
          word_o     <= acc;
          word_valid <= 1'b1;
        end else overrun <= 1'b1;
      end else if (word_valid && word_ready) word_valid <= 1'b0;
      if (frame_err) begin
        st  <= HUNT;
        idx <= '0;
      end else if (byte_valid) begin
        case (st)
          // Four shifts leave the first byte in the MSB; idx wraps back to 0.
          COLLECT: begin
            acc <= {acc[23:0], byte_o};
            idx <= idx + 2'd1;
            if (idx == 2'd3) st <= CR;
          end
          CR: if (byte_o == CHR_CR) st <= LF;
            else begin
              line_err <= 1'b1;
              st       <= byte_o == CHR_LF ? COLLECT : HUNT;
            end
          LF: begin
            line_err <= byte_o != CHR_LF;
            st       <= byte_o == CHR_LF ? COLLECT : HUNT;
          end
          HUNT: if (byte_o == CHR_LF) st <= COLLECT;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_line_rx.sv
// tb_uart_line_rx: scoreboard bench for uart_line_rx at 16 clocks per bit
module tb_uart_line_rx;
  localparam int DIV = 16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b1;
  logic        word_ready = 1'b0;
  logic [7:0]  byte_o;
  logic        byte_valid, word_valid, frame_err, line_err, overrun;
  logic [31:0] word_o;
  int          checks = 0, errors = 0;
  int          cyc = 0, last_bv = 0, bv_n = 0, fe_n = 0, le_n = 0, ov_n = 0;
  logic        wv_q = 1'b0;
  logic [7:0]  eb;
  logic [7:0]  exp_bytes[$];
  logic [31:0] exp_words[$];

  uart_line_rx #(.CLOCK_FREQ(1600), .BAUD_RATE(100)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .byte_o(byte_o),
    .byte_valid(byte_valid),
    .word_o(word_o),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .frame_err(frame_err),
    .line_err(line_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  // Byte scoreboard, pulse counters and word_valid latency after the LF byte.
  always @(negedge clk) begin
    cyc++;
    if (byte_valid) begin
      bv_n++;
      last_bv = cyc;
      checks++;
      if (exp_bytes.size() == 0) begin
        errors++;
        $display("FAIL byte_unexpected got %h want none", byte_o);
      end else begin
        eb = exp_bytes.pop_front();
        if (byte_o !== eb) begin
          errors++;
          $display("FAIL byte_data got %h want %h", byte_o, eb);
        end
      end
    end
    if (frame_err) fe_n++;
    if (line_err) le_n++;
    if (overrun) ov_n++;
    if (word_valid && !wv_q) begin
      checks++;
      if (cyc - last_bv !== 1) begin
        errors++;
        $display("FAIL word_latency got %0d want 1", cyc - last_bv);
      end
    end
    wv_q = word_valid;
  end

  task automatic send_byte(input logic [7:0] b, input logic stop);
    if (stop) exp_bytes.push_back(b);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_line(input logic [31:0] w, input logic [7:0] c, input logic [7:0] l);
    for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
    send_byte(c, 1'b1);
    send_byte(l, 1'b1);
  endtask

  task automatic accept();
    word_ready = 1'b1;
    @(negedge clk);
    word_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({byte_o, byte_valid, word_o, word_valid, frame_err, line_err, overrun} !== 45'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h/%b/%h/%b/%b%b%b want all 0", byte_o, byte_valid, word_o, word_valid, frame_err, line_err, overrun);
    end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    checks++;
    if ({byte_valid, word_valid, frame_err, line_err, overrun} !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle got %b want 00000", {byte_valid, word_valid, frame_err, line_err, overrun});
    end
  endtask

  task automatic test_basic();
    logic [31:0] ew;
    int b0;
    b0 = bv_n;
    exp_words.push_back(32'h41424344);
    send_line(32'h41424344, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (bv_n - b0 !== 6) begin
      errors++;
      $display("FAIL basic_byte_count got %0d want 6", bv_n - b0);
    end
    checks++;
    if (word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_word got %h/%b want %h/1", word_o, word_valid, ew);
    end
    repeat (20) @(negedge clk);
    checks++;
    if (word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL basic_hold got %h/%b want %h/1", word_o, word_valid, ew);
    end
    accept();
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_accept got %b want 0", word_valid);
    end
  endtask

  task automatic test_frame_err();
    logic [31:0] ew;
    int f0, l0;
    f0 = fe_n;
    l0 = le_n;
    send_byte(8'h41, 1'b1);
    send_byte(8'h42, 1'b0);
    send_byte(8'h43, 1'b1);
    send_byte(8'h44, 1'b1);
    send_byte(8'h0D, 1'b1);
    send_byte(8'h0A, 1'b1);
    checks++;
    if (fe_n - f0 !== 1 || le_n - l0 !== 0) begin
      errors++;
      $display("FAIL frame_pulses got fe=%0d le=%0d want fe=1 le=0", fe_n - f0, le_n - l0);
    end
    checks++;
    if (word_valid !== 1'b0) begin
      errors++;
      $display("FAIL frame_no_word got %b want 0", word_valid);
    end
    exp_words.push_back(32'h5758595A);
    send_line(32'h5758595A, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL frame_recover got %h/%b want %h/1", word_o, word_valid, ew);
    end
    accept();
  endtask

  task automatic test_glitch();
    logic [31:0] ew;
    int b0, f0;
    b0 = bv_n;
    f0 = fe_n;
    rx = 1'b0;
    repeat (6) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (bv_n - b0 !== 0 || fe_n - f0 !== 0) begin
      errors++;
      $display("FAIL glitch_pulses got bv=%0d fe=%0d want 0 0", bv_n - b0, fe_n - f0);
    end
    exp_words.push_back(32'h61626364);
    send_line(32'h61626364, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL glitch_then_line got %h/%b want %h/1", word_o, word_valid, ew);
    end
    accept();
  endtask

  task automatic test_line_err();
    logic [31:0] ew;
    int l0;
    l0 = le_n;
    send_line(32'h41424344, 8'h58, 8'h0A);
    checks++;
    if (le_n - l0 !== 1 || word_valid !== 1'b0) begin
      errors++;
      $display("FAIL line_err_pulse got le=%0d wv=%b want le=1 wv=0", le_n - l0, word_valid);
    end
    exp_words.push_back(32'h31323334);
    send_line(32'h31323334, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL line_err_recover got %h/%b want %h/1", word_o, word_valid, ew);
    end
    accept();
    exp_words.push_back(32'h0D0A0D0A);
    send_line(32'h0D0A0D0A, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (word_o !== ew || word_valid !== 1'b1 || le_n - l0 !== 1) begin
      errors++;
      $display("FAIL delimiter_payload got %h/%b le=%0d want %h/1 le=1", word_o, word_valid, le_n - l0, ew);
    end
    accept();
  endtask

  task automatic test_overrun();
    logic [31:0] ew;
    int o0;
    bit seen;
    o0 = ov_n;
    exp_words.push_back(32'h45464748);
    send_line(32'h45464748, 8'h0D, 8'h0A);
    send_line(32'h494A4B4C, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (ov_n - o0 !== 1 || word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_drop got ov=%0d %h/%b want ov=1 %h/1", ov_n - o0, word_o, word_valid, ew);
    end
    accept();
    o0 = ov_n;
    send_line(32'h4D4E4F50, 8'h0D, 8'h0A);
    exp_words.push_back(32'h51525354);
    for (int i = 3; i >= 0; i--) send_byte(8'h51 + 8'(3 - i), 1'b1);
    send_byte(8'h0D, 1'b1);
    seen = 1'b0;
    fork
      send_byte(8'h0A, 1'b1);
      for (int i = 0; i < 300 && !seen; i++) begin
        @(negedge clk);
        if (byte_valid) begin
          seen = 1'b1;
          word_ready = 1'b1;
          @(negedge clk);
          word_ready = 1'b0;
        end
      end
    join
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL overrun_lf_timeout got none want byte_valid");
    end
    ew = exp_words.pop_front();
    checks++;
    if (ov_n - o0 !== 0 || word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL ready_reload got ov=%0d %h/%b want ov=0 %h/1", ov_n - o0, word_o, word_valid, ew);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] ew;
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      rx = i[0] ? 1'b0 : (i == 0);
      repeat (DIV) @(negedge clk);
    end
    rx = 1'b0;
    repeat (DIV / 2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({byte_o, byte_valid, word_o, word_valid, frame_err, line_err, overrun} !== 45'd0) begin
      errors++;
      $display("FAIL reset_async got %h/%b/%h/%b/%b%b%b want all 0", byte_o, byte_valid, word_o, word_valid, frame_err, line_err, overrun);
    end
    rx = 1'b1;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    exp_words.push_back(32'h41424344);
    send_line(32'h41424344, 8'h0D, 8'h0A);
    ew = exp_words.pop_front();
    checks++;
    if (word_o !== ew || word_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_recover got %h/%b want %h/1", word_o, word_valid, ew);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_frame_err();
    test_glitch();
    test_line_err();
    test_overrun();
    test_reset_mid();
    repeat (5) @(negedge clk);
    checks++;
    if (exp_bytes.size() != 0) begin
      errors++;
      $display("FAIL bytes_missing got %0d left want 0", exp_bytes.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_line_rx.md
# uart_line_rx

UART receive end for the pin-scan link. It decodes the serial stream produced by the pin-scan transmitter: 8N1, LSB first, lines of four payload bytes followed by CR (0x0D) and LF (0x0A). It assembles each line into a 32-bit word, with the first byte received in the MSB, and presents the word on a valid/ready interface to host-side logic, e.g. a capture FIFO or display.

## Interface
- CLOCK_FREQ, 50000000: clk frequency in Hz.
- BAUD_RATE, 115200: line rate.
- clk  input  1  sole clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line; idles high.
- byte_o  output  8  last received byte; reset 8'h00.
- byte_valid  output  1  one-cycle pulse per good byte; reset 0.
- word_o  output  32  assembled word {b0,b1,b2,b3}; reset 0.
- word_valid  output  1  word available; reset 0.
- word_ready  input  1  consumer accepts word_o.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low; reset 0.
- line_err  output  1  one-cycle pulse when the CR or LF position holds a wrong byte; reset 0.
- overrun  output  1  one-cycle pulse when a word completes while the previous word is unaccepted; reset 0.

## Operation
- Input synchronizer: rx passes through 2 flops, which reset to 1. The FSM only sees the synchronized rx_s.
- Timing constants: DIV = CLOCK_FREQ/BAUD_RATE, using integer division. HALF = DIV/2. The bit counter is 20 bits, and elaboration fails if DIV ≥ 2^20 or DIV < 4.
- Byte FSM states: IDLE, START, DATA, STOP.
  - IDLE: on a falling edge of rx_s (previous 1, now 0), load counter with HALF and go to START. A line held low continuously does not re-trigger.
  - START: when the counter reaches 0, sample rx_s. If the sample is 1, treat it as a false start and return to IDLE with no pulse. If 0, load DIV, clear bitpos, and go to DATA.
  - DATA: on each counter expiry, shift rx_s into bit[bitpos] and reload DIV. After bitpos 7, go to STOP.
  - STOP: on expiry, sample rx_s. If 1, update byte_o and pulse byte_valid. If 0, pulse frame_err and leave byte_o unchanged. Either way, go to IDLE.
- Line assembler states: COLLECT (idx 0..3), CR, LF, HUNT. Reset state is COLLECT with idx 0.
  - COLLECT: store the byte into slot idx. After idx 3, go to CR.
  - CR: if the byte is 0x0D, go to LF. Otherwise pulse line_err and go to HUNT; if that byte was 0x0A, go to COLLECT instead.
  - LF: if the byte is 0x0A, the word is complete and the state goes to COLLECT. Otherwise pulse line_err and go to HUNT.
  - HUNT: discard bytes until 0x0A, then go to COLLECT.
  - frame_err in any state: discard the partial line and go to HUNT. line_err does not pulse.
- Output holding register behaviour on word completion:
  - word_valid=0: load word_o and set word_valid.
  - word_valid=1 and word_ready=1 in the same cycle: load the new word and keep word_valid=1. No overrun.
  - word_valid=1 and word_ready=0: keep the old word and pulse overrun. The new word is dropped.
  - Otherwise, word_valid clears on the cycle after word_valid && word_ready.
- Payload bytes equal to 0x0D or 0x0A in slots 0..3 are data, not delimiters.

## Timing
- Sample points are measured from the first clk where rx_s=0:
  - start check at HALF;
  - data bit k at HALF+(k+1)·DIV;
  - stop bit at HALF+9·DIV.
- Two cycles of synchronizer latency precede rx_s.
- byte_valid and frame_err are registered; they assert in the cycle after the stop sample.
- word_valid rises 1 cycle after the byte_valid of the LF byte. line_err and overrun also assert 1 cycle after the offending byte_valid.
- Back-to-back frames are accepted: a new falling edge may occur in the cycle after the stop sample.
- rst_n low mid-frame: all state and outputs return to their reset values immediately. After release, the receiver waits for a fresh falling edge.

## Structure
- Package uart_pkg:
  - DIV/HALF computation function;
  - CHR_CR=8'h0D and CHR_LF=8'h0A;
  - byte FSM and line FSM state enums.
- Sub-module uart_rx_byte holds the synchronizer, the byte FSM and the counter. Its outputs are byte_o, byte_valid and frame_err.
- uart_line_rx instantiates uart_rx_byte and holds the assembler and the holding register.

## Test plan
- Bench parameters: CLOCK_FREQ=1600, BAUD_RATE=100, giving DIV=16.
- Send "ABCD\r\n" with word_ready=0 → six byte_valid pulses; word_o=0x41424344 and word_valid=1, held; word_ready pulse → word_valid=0 on the next cycle.
- 0x42 sent with stop bit 0 inside a line → frame_err pulse, no word; the rest of the line is discarded up to LF; then "WXYZ\r\n" → word_o=0x5758595A.
- rx low glitch of 6 cycles → no byte_valid, no frame_err; FSM back in IDLE.
- Send "ABCDX\n" → line_err at the X byte; the following "1234\r\n" → word_o=0x31323334. Then "\r\n\r\n\r\n" → word_o=0x0D0A0D0A.
- Two lines with word_ready=0 → overrun pulse; word_o stays the first word. Repeat with word_ready=1 in the completion cycle → no overrun; word_o holds the second word.
- rst_n asserted at data bit 4 → all outputs 0 at once; after release, a full "ABCD\r\n" yields 0x41424344.
